// File: rtl/token_rr_dispatcher.sv
// token_rr_dispatcher: round-robin one-hot token grant over masked channels with idle interval; TOKEN_TIMEOUT_EN adds grant abort
module token_rr_dispatcher #(
  parameter int N_CH        = 17,
  parameter int CNT_W       = 33,
  parameter int CH_W        = $clog2(N_CH),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] interval_i,
  input  logic             trig_i,
  input  logic [N_CH-1:0]  en_mask_i,
  input  logic [N_CH-1:0]  TokenReady_i,
  output logic [N_CH-1:0]  TokenValid_o,
  output logic [CH_W-1:0]  cur_ch_o,
  output logic             busy_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {WAIT, SEL, GRANT} state_t;
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] slack_q, slack_d, ival_q, ival_d, ival_eff, lim;
  logic             fresh_q, fresh_d, tmo_q, tmo_d, hit, rdy, abort;
  logic [CH_W-1:0]  ptr_q, ptr_d, cur_q, cur_d, pick, nxt;
`ifdef TOKEN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] gcnt_q, gcnt_d;
  assign abort = gcnt_q == TW'(TIMEOUT_CYC - 1);
`else
  assign abort = 1'b0;
`endif
  // fresh_q marks the first WAIT cycle, where interval_i is captured
  assign ival_eff = fresh_q ? interval_i : ival_q;
  assign lim      = (ival_eff == '0) ? '0 : ival_eff - 1'b1;
  assign rdy      = TokenReady_i[cur_q];
  assign nxt      = (cur_q == LAST) ? '0 : cur_q + 1'b1;
  // first enabled channel at or above ptr, wrapping; lowest offset wins
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en_mask_i[(int'(ptr_q) + k >= N_CH) ? int'(ptr_q) + k - N_CH : int'(ptr_q) + k]) begin
        hit  = 1'b1;
        pick = CH_W'((int'(ptr_q) + k >= N_CH) ? int'(ptr_q) + k - N_CH : int'(ptr_q) + k);
      end
    end
  end
  // next-state logic for WAIT/SEL/GRANT
  always_comb begin
    state_d = state_q;
    slack_d = slack_q;
    ival_d  = ival_q;
    fresh_d = 1'b0;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    tmo_d   = 1'b0;
`ifdef TOKEN_TIMEOUT_EN
    gcnt_d  = gcnt_q;
`endif
    unique case (state_q)
      WAIT: begin
        ival_d  = ival_eff;
        slack_d = (&slack_q) ? slack_q : slack_q + 1'b1;
        state_d = (trig_i || slack_q == lim) ? SEL : WAIT;
      end
      SEL: begin
        cur_d   = hit ? pick : cur_q;
        state_d = hit ? GRANT : WAIT;
        slack_d = '0;
        fresh_d = !hit;
`ifdef TOKEN_TIMEOUT_EN
        gcnt_d  = '0;
`endif
      end
      GRANT: begin
`ifdef TOKEN_TIMEOUT_EN
        gcnt_d = gcnt_q + 1'b1;
`endif
        if (rdy || abort) begin
          ptr_d   = nxt;
          state_d = WAIT;
          slack_d = '0;
          fresh_d = 1'b1;
          tmo_d   = !rdy;
        end
      end
      default: state_d = WAIT;
    endcase
  end
  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT;
      slack_q <= '0;
      ival_q  <= '0;
      fresh_q <= 1'b1;
      ptr_q   <= '0;
      cur_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slack_q <= slack_d;
      ival_q  <= ival_d;
      fresh_q <= fresh_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
    end
  end
`ifdef TOKEN_TIMEOUT_EN
  // grant duration counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) gcnt_q <= '0;
    else gcnt_q <= gcnt_d;
  end
`endif
  assign TokenValid_o = (state_q == GRANT) ? (N_CH'(1) << cur_q) : '0;
  assign cur_ch_o     = cur_q;
  assign busy_o       = state_q != WAIT;
  assign timeout_o    = tmo_q;
endmodule

// File: tb/tb_token_rr_dispatcher.sv
// tb_token_rr_dispatcher: scoreboard bench for token_rr_dispatcher
module tb_token_rr_dispatcher;
  localparam int N = 17;
  localparam int CW = 33;
  localparam logic [N-1:0] ALL = '1;
  typedef struct {int ch; int gap;} exp_t;
  logic          clk = 1'b0;
  logic          rstn;
  logic [CW-1:0] ival;
  logic          trig;
  logic [N-1:0]  mask, rdy;
  logic [N-1:0]  TokenValid_o;
  logic [4:0]    cur_ch_o;
  logic          busy_o, timeout_o;
  exp_t          exp_q[$];
  exp_t          e;
  int            n_chk = 0, n_err = 0, cyc = 0, last_ev = 0, ptr = 0;
  logic [N-1:0]  prv_v = '0;
  logic          prv_rst = 1'b0;

  token_rr_dispatcher #(.N_CH(N), .CNT_W(CW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn), .interval_i(ival), .trig_i(trig), .en_mask_i(mask),
    .TokenReady_i(rdy), .TokenValid_o(TokenValid_o), .cur_ch_o(cur_ch_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_grant(input int gap);
    int c;
    c = -1;
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) begin
        c = (ptr + k) % N;
        break;
      end
    end
    exp_q.push_back('{c, gap});
    ptr = (c + 1) % N;
  endtask

  task automatic drain(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_rise(input int budget);
    logic [N-1:0] p;
    int n;
    p = TokenValid_o;
    for (n = 0; n < budget; n++) begin
      step();
      if (TokenValid_o != '0 && p == '0) break;
      p = TokenValid_o;
    end
    check("grant_rise", 64'(n < budget), 64'd1);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rstn && !prv_rst) last_ev = cyc;
    if (rstn && TokenValid_o != '0 && prv_v == '0) begin
      if (exp_q.size() == 0) check("unexpected_grant", 64'(TokenValid_o), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("grant_ch", 64'(TokenValid_o), 64'd1 << e.ch);
        check("cur_ch", 64'(cur_ch_o), 64'(e.ch));
        if (e.gap != 0) check("grant_gap", 64'(cyc - last_ev), 64'(e.gap));
      end
      last_ev = cyc;
    end
    prv_v   = TokenValid_o;
    prv_rst = rstn;
  end

  initial begin
    int busy_n, tmo_n, bad;
    logic [N-1:0] seen;
    rstn = 1'b1; ival = 10; trig = 1'b0; mask = ALL; rdy = ALL;
    #1 rstn = 1'b0;
    step(); step();
    check("rst_valid", 64'(TokenValid_o), 64'd0);
    check("rst_cur", 64'(cur_ch_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    expect_grant(11);
    for (int i = 1; i < 18; i++) expect_grant(12);
    @(posedge clk); #2 rstn = 1'b1;
    drain(300);
    mask = 17'h00005;
    for (int i = 0; i < 4; i++) expect_grant(12);
    drain(80);
    mask = ALL; ival = 1000;
    expect_grant(8);
    for (int i = 0; i < 6; i++) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("trig_sel_valid", 64'(TokenValid_o), 64'd0);
    check("trig_sel_busy", 64'(busy_o), 64'd1);
    step();
    check("trig_grant", 64'(TokenValid_o), 64'd1 << 1);
    trig = 1'b1;
    expect_grant(1002);
    step();
    trig = 1'b0;
    check("trig_drop_busy", 64'(busy_o), 64'd0);
    drain(1100);
    ival = 10; mask = '0;
    busy_n = 0; seen = '0;
    for (int i = 0; i < 44; i++) begin
      step();
      busy_n += int'(busy_o);
      seen |= TokenValid_o;
    end
    check("nomask_busy", 64'(busy_n), 64'd4);
    check("nomask_valid", 64'(seen), 64'd0);
    step();
    mask = 17'h10000;
    expect_grant(56);
    drain(80);
    mask = ALL;
    expect_grant(12);
    drain(40);
    step();
    rdy = '0;
    expect_grant(12);
`ifdef TOKEN_TIMEOUT_EN
    expect_grant(19);
    wait_rise(40);
    for (int i = 0; i < 7; i++) step();
    check("tmo_hold_valid", 64'(TokenValid_o), 64'd1 << 1);
    check("tmo_early", 64'(timeout_o), 64'd0);
    step();
    check("tmo_pulse", 64'(timeout_o), 64'd1);
    check("tmo_drop_valid", 64'(TokenValid_o), 64'd0);
    step();
    check("tmo_single", 64'(timeout_o), 64'd0);
    wait_rise(40);
    rdy = ALL;
    drain(5);
`else
    wait_rise(40);
    bad = 0; tmo_n = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      bad += int'(TokenValid_o != 17'h00002);
      tmo_n += int'(timeout_o);
    end
    check("hold_valid", 64'(bad), 64'd0);
    check("hold_timeout", 64'(tmo_n), 64'd0);
    rdy = ALL;
    step();
    check("hold_release", 64'(TokenValid_o), 64'd0);
`endif
    step();
    rdy = '0; mask = 17'h00020;
    expect_grant(0);
    wait_rise(40);
    rstn = 1'b0;
    #1;
    check("arst_valid", 64'(TokenValid_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_cur", 64'(cur_ch_o), 64'd0);
    mask = ALL; rdy = ALL; ival = 10; ptr = 0;
    step(); step();
    expect_grant(11);
    expect_grant(12);
    @(posedge clk); #2 rstn = 1'b1;
    drain(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
